// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative RV32M divider.
// Holds the op encoding, FSM state enum, iteration constants, the
// RISC-V special-case result constants and small two's-complement helpers.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int         ITER_COUNT = 32;
    // Counter value loaded at capture; CALC runs while it walks 31 -> 0.
    localparam logic [4:0] ITER_LAST  = 5'd31;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND  = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR   = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT      = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } div_state_e;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // DIV and REM (op[0] == 0) are the signed operations.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU (op[1] == 1) return the remainder.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/DSPsubtractor.sv
// DSPsubtractor: 32-bit combinational subtractor, out = input1 - input2.
// Ports: input1, input2 (operands), out (difference, modulo 2^32).
module DSPsubtractor (
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic [31:0] out
);

    assign out = input1 - input2;

endmodule

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts {rem, quot} left by one, subtracts the divisor magnitude through
// the DSP subtractor and keeps the difference when the shifted remainder
// is not smaller than the divisor.
// Ports: rem_in/quot_in (current state), divisor (magnitude),
//        rem_out/quot_out (state after this iteration).
module div_step
    import div_pkg::*;
(
    input  logic [32:0] rem_in,
    input  logic [31:0] quot_in,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic [31:0] quot_out
);

    logic [32:0] rem_sh_s;
    logic [31:0] quot_sh_s;
    logic [31:0] diff_s;
    logic        borrow_s;
    logic        ge_s;

    assign rem_sh_s  = {rem_in[31:0], quot_in[31]};
    assign quot_sh_s = {quot_in[30:0], 1'b0};

    DSPsubtractor u_sub (
        .input1 (rem_sh_s[31:0]),
        .input2 (divisor),
        .out    (diff_s)
    );

    // Borrow out of the 32-bit subtract, recovered from the operand and
    // result sign bits so no separate magnitude comparator is needed.
    assign borrow_s = (~rem_sh_s[31] & divisor[31])
                    | (~(rem_sh_s[31] ^ divisor[31]) & diff_s[31]);

    // rem_in[32] is zero by construction (rem < divisor after every step);
    // folding it in keeps the full 33-bit state part of the compare.
    assign ge_s = rem_sh_s[32] | rem_in[32] | ~borrow_s;

    // Restore-or-keep selection for the next remainder and quotient bit.
    always_comb begin
        rem_out  = rem_sh_s;
        quot_out = quot_sh_s;
        if (ge_s) begin
            rem_out  = {1'b0, diff_s};
            quot_out = {quot_sh_s[31:1], 1'b1};
        end else begin
            rem_out  = rem_sh_s;
            quot_out = {quot_sh_s[31:1], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Restoring shift-subtract over 32 CALC cycles followed by one FIX cycle
// for sign correction; start/busy/done handshake towards the ALU sequencer.
// Ports: clk, reset (sync, active high), start, op[1:0], dividend, divisor,
//        busy, done (1-cycle pulse), result (held until next done).
// Config: define DIV_FASTPATH_EN to send divide-by-zero and signed overflow
//         straight from IDLE to FIX (done in cycle 2 instead of 34).
module div_iter_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e  state_r, state_next_s;
    logic [4:0]  count_r;
    logic [1:0]  op_r;
    logic [31:0] divisor_mag_r;
    logic [32:0] rem_r;
    logic [31:0] quot_r;
    logic        q_neg_r, r_neg_r;
    logic        special_r;
    logic [31:0] special_res_r;
    logic        busy_r, done_r;
    logic [31:0] result_r;

    logic        accept_s, calc_s, fix_s;
    logic        sgn_s, dvd_neg_s, dvs_neg_s;
    logic        special_s;
    logic [31:0] special_val_s;
    logic [32:0] rem_next_s;
    logic [31:0] quot_next_s;
    logic [31:0] q_fix_s, r_fix_s, fix_val_s;

    assign sgn_s     = op_is_signed(op);
    assign dvd_neg_s = sgn_s & dividend[31];
    assign dvs_neg_s = sgn_s & divisor[31];

    // Special-case detection and its architecturally mandated result.
    always_comb begin
        special_s     = 1'b0;
        special_val_s = 32'd0;
        if (divisor == 32'd0) begin
            special_s     = 1'b1;
            special_val_s = op_is_rem(op) ? dividend : DIV_ZERO_QUOT;
        end else if (sgn_s && (dividend == OVF_DIVIDEND) && (divisor == OVF_DIVISOR)) begin
            special_s     = 1'b1;
            special_val_s = op_is_rem(op) ? 32'd0 : OVF_QUOT;
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'd0;
        end
    end

    div_step u_step (
        .rem_in   (rem_r),
        .quot_in  (quot_r),
        .divisor  (divisor_mag_r),
        .rem_out  (rem_next_s),
        .quot_out (quot_next_s)
    );

    // Sign correction and quotient/remainder selection for the FIX cycle.
    always_comb begin
        q_fix_s   = q_neg_r ? neg32(quot_r) : quot_r;
        r_fix_s   = r_neg_r ? neg32(rem_r[31:0]) : rem_r[31:0];
        fix_val_s = 32'd0;
        if (special_r) begin
            fix_val_s = special_res_r;
        end else if (op_is_rem(op_r)) begin
            fix_val_s = r_fix_s;
        end else begin
            fix_val_s = q_fix_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_FASTPATH_EN
                    state_next_s = special_s ? S_FIX : S_CALC;
`else
                    state_next_s = S_CALC;
`endif
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (count_r == 5'd0) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_CALC;
                end
            end
            S_FIX:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM output decode: datapath control strobes.
    always_comb begin
        accept_s = 1'b0;
        calc_s   = 1'b0;
        fix_s    = 1'b0;
        case (state_r)
            S_IDLE:  accept_s = start;
            S_CALC:  calc_s   = 1'b1;
            S_FIX:   fix_s    = 1'b1;
            default: begin
                accept_s = 1'b0;
                calc_s   = 1'b0;
                fix_s    = 1'b0;
            end
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r       <= 5'd0;
            op_r          <= 2'b00;
            divisor_mag_r <= 32'd0;
            rem_r         <= 33'd0;
            quot_r        <= 32'd0;
            q_neg_r       <= 1'b0;
            r_neg_r       <= 1'b0;
            special_r     <= 1'b0;
            special_res_r <= 32'd0;
        end else if (accept_s) begin
            count_r       <= ITER_LAST;
            op_r          <= op;
            divisor_mag_r <= dvs_neg_s ? neg32(divisor) : divisor;
            rem_r         <= 33'd0;
            // Quotient register starts out holding the dividend magnitude;
            // its bits shift into rem as quotient bits shift in.
            quot_r        <= dvd_neg_s ? neg32(dividend) : dividend;
            q_neg_r       <= dvd_neg_s ^ dvs_neg_s;
            r_neg_r       <= dvd_neg_s;
            special_r     <= special_s;
            special_res_r <= special_val_s;
        end else if (calc_s) begin
            rem_r   <= rem_next_s;
            quot_r  <= quot_next_s;
            count_r <= (count_r != 5'd0) ? (count_r - 5'd1) : 5'd0;
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            done_r <= fix_s;
            if (fix_s) begin
                result_r <= fix_val_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: scoreboard bench for div_iter_unit. Stimulus pushes the
// expected result and completion cycle; a negedge monitor pops on done.
module tb_div_iter_unit;

    localparam logic [1:0] T_DIV  = 2'b00;
    localparam logic [1:0] T_DIVU = 2'b01;
    localparam logic [1:0] T_REM  = 2'b10;
    localparam logic [1:0] T_REMU = 2'b11;

`ifdef DIV_FASTPATH_EN
    localparam int FAST_LAT = 2;
`else
    localparam int FAST_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    div_iter_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int got, input int want);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit sp;
        sp = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return sp ? FAST_LAT : 34;
    endfunction

    // Called #1 after a rising edge; holds start for that one cycle.
    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input string name, input bit track);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        if (track) sb_q.push_back('{exp, cyc + lat_of(o, a, b), name});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (sb_q.size() == 0 && !busy) return;
            @(posedge clk); #1;
        end
        fail_now("wait_idle timeout, pending ops", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
        drive_start(o, a, b, exp, name, 1'b1);
        wait_idle();
    endtask

    // Monitor: compare result and completion cycle whenever done is seen.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    fail_now("spurious_done at cycle", cyc, -1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check({mon_e.name, " result"}, result, mon_e.res);
                    check({mon_e.name, " done cycle"}, 32'(cyc), 32'(mon_e.due));
                    check({mon_e.name, " busy at done"}, {31'd0, busy}, 32'd0);
                end
                if (done_prev) fail_now("done_width, consecutive done cycles", 2, 1);
            end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                mon_e = sb_q.pop_front();
                fail_now({mon_e.name, " done timeout, cycle"}, cyc, mon_e.due);
            end
        end
        done_prev <= done;
    end

    initial begin
        int c0;
        reset = 1'b1; start = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result,        32'd0);

        // DIVU 100/7 with a cycle-by-cycle busy trace.
        drive_start(T_DIVU, 32'd100, 32'd7, 32'd14, "divu 100/7", 1'b1);
        for (int k = 1; k <= 34; k++) begin
            check($sformatf("busy cycle %0d", k), {31'd0, busy}, (k <= 33) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        wait_idle();

        run(T_REMU, 32'd100,       32'd7,          32'd2,          "remu 100/7");
        run(T_DIV,  32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   "div -100/7");
        run(T_REM,  32'hFFFFFF9C,  32'd7,          32'hFFFFFFFE,   "rem -100/7");
        run(T_DIV,  32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,   "div 100/-7");
        run(T_REM,  32'd100,       32'hFFFFFFF9,   32'd2,          "rem 100/-7");
        run(T_DIV,  32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   "div 7/-2");
        run(T_REM,  32'd7,         32'hFFFFFFFE,   32'd1,          "rem 7/-2");
        run(T_DIVU, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   "divu max/1");
        run(T_REMU, 32'hFFFFFFFF,  32'h10,         32'h0000000F,   "remu max/16");
        run(T_DIVU, 32'h80000000,  32'hFFFFFFFF,   32'd0,          "divu 2^31/max");
        run(T_REMU, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   "remu 2^31/max");
        run(T_DIVU, 32'd5,         32'd0,          32'hFFFFFFFF,   "divu 5/0");
        run(T_REM,  32'd5,         32'd0,          32'd5,          "rem 5/0");
        run(T_DIV,  32'hFFFFFFFB,  32'd0,          32'hFFFFFFFF,   "div -5/0");
        run(T_REMU, 32'd5,         32'd0,          32'd5,          "remu 5/0");
        run(T_DIV,  32'h80000000,  32'hFFFFFFFF,   32'h80000000,   "div overflow");
        run(T_REM,  32'h80000000,  32'hFFFFFFFF,   32'd0,          "rem overflow");

        // Start while busy must be ignored.
        drive_start(T_DIVU, 32'd1000, 32'd10, 32'd100, "divu busy-start", 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = T_REMU; dividend = 32'd7; divisor = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Start in the done cycle is accepted (back-to-back).
        drive_start(T_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, "b2b first", 1'b1);
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk); #1;
        end
        if (done) begin
            drive_start(T_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, "b2b second", 1'b1);
        end else begin
            fail_now("b2b done never seen", 0, 1);
        end
        wait_idle();

        // Reset in cycle 10 aborts the operation with no done.
        c0 = cyc;
        drive_start(T_DIVU, 32'd100, 32'd7, 32'd0, "aborted", 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset-abort start cycle", 32'(cyc - c0), 32'd11);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("abort busy +%0d", k),   {31'd0, busy}, 32'd0);
            check($sformatf("abort done +%0d", k),   {31'd0, done}, 32'd0);
            check($sformatf("abort result +%0d", k), result,        32'd0);
            @(posedge clk); #1;
        end

        run(T_DIVU, 32'd100, 32'd7, 32'd14, "divu after reset");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
